// File: rtl/servo_position_driver.sv
// Pan servo driver: integrates dir/val/done step requests into a saturating 8-bit
// position, rate-limited to one update per tick, and emits one PWM pulse per frame.
module servo_position_driver #(
    parameter int unsigned PERIOD_CYCLES = 540000,
    parameter int unsigned PULSE_MIN     = 27000,
    parameter int unsigned PULSE_SCALE   = 105,
    parameter int unsigned UPDATE_CYCLES = 270000,
    parameter logic [7:0]  POS_MIN       = 8'd0,
    parameter logic [7:0]  POS_MAX       = 8'd255,
    parameter logic [7:0]  POS_CENTER    = 8'd128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dir,
    input  logic [7:0] val,
    input  logic       done,
    input  logic       recenter,
    output logic [7:0] position,
    output logic       pwm,
    output logic       at_min,
    output logic       at_max,
    output logic       frame_start
);

    localparam logic [19:0] UPDATE_LAST = 20'(UPDATE_CYCLES - 1);
    localparam logic [19:0] PERIOD_LAST = 20'(PERIOD_CYCLES - 1);
    localparam logic [19:0] WIDTH_BASE  = 20'(PULSE_MIN);
    localparam logic [19:0] WIDTH_STEP  = 20'(PULSE_SCALE);

    logic [19:0] update_cnt;
    logic [19:0] frame_cnt;
    logic [19:0] width;
    logic [19:0] width_next;
    logic        tick;

    logic        pend_valid;
    logic        pend_dir;
    logic [7:0]  pend_val;

    logic        step_dir;
    logic [7:0]  step_val;
    logic [8:0]  step_sum;
    logic [8:0]  step_floor;
    logic [7:0]  step_result;

    assign tick        = (update_cnt == UPDATE_LAST);
    assign frame_start = (frame_cnt == '0) && !reset;
    assign at_min      = (position == POS_MIN);
    assign at_max      = (position == POS_MAX);
    assign width_next  = WIDTH_BASE + 20'(position) * WIDTH_STEP;

    // A live request in the tick cycle beats the stored one; the 9-bit sums catch wrap.
    // NOTE: every output is assigned first so this block cannot infer a latch.
    always_comb begin
        step_dir    = done ? dir : pend_dir;
        step_val    = done ? val : pend_val;
        step_sum    = {1'b0, position} + {1'b0, step_val};
        step_floor  = {1'b0, POS_MIN} + {1'b0, step_val};
        step_result = position;
        if (!step_dir) begin
            step_result = (step_sum > {1'b0, POS_MAX}) ? POS_MAX : step_sum[7:0];
        end else begin
            step_result = ({1'b0, position} < step_floor) ? POS_MIN : position - step_val;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            update_cnt <= '0;
        end else begin
            update_cnt <= tick ? '0 : update_cnt + 20'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            position   <= POS_CENTER;
            pend_valid <= 1'b0;
            pend_dir   <= 1'b0;
            pend_val   <= '0;
        end else if (recenter) begin
            position   <= POS_CENTER;
            pend_valid <= 1'b0;
        end else if (tick) begin
            if (done || pend_valid) begin
                position <= step_result;
            end
            pend_valid <= 1'b0;
        end else if (done) begin
            pend_valid <= 1'b1;
            pend_dir   <= dir;
            pend_val   <= val;
        end
    end

    // Width is sampled once per frame, so mid-frame position moves only affect the next pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt <= '0;
            width     <= '0;
            pwm       <= 1'b0;
        end else begin
            frame_cnt <= (frame_cnt == PERIOD_LAST) ? '0 : frame_cnt + 20'd1;
            if (frame_start) begin
                width <= width_next;
                pwm   <= (width_next != '0);
            end else begin
                pwm   <= (frame_cnt < width);
            end
        end
    end

endmodule

// File: tb/tb_servo_position_driver.sv
// Scoreboarded bench for servo_position_driver: a cycle-level reference model queues
// expected outputs for two instances (POS_MIN 0 and 20); a negedge monitor compares them.
module tb_servo_position_driver;

    localparam int PER     = 1000;
    localparam int PWIDTH  = 100;
    localparam int PSCALE  = 2;
    localparam int UPD     = 50;
    localparam int CENTER  = 128;
    localparam int PMAX    = 255;
    localparam int PMIN_A  = 0;
    localparam int PMIN_B  = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dir = 1'b0;
    logic [7:0] val = 8'd0;
    logic       done = 1'b0;
    logic       recenter = 1'b0;

    logic [7:0] pos_a, pos_b;
    logic       pwm_a, pwm_b, min_a, min_b, max_a, max_b, fs_a, fs_b;

    always #5 clock = ~clock;

    servo_position_driver #(
        .PERIOD_CYCLES(PER), .PULSE_MIN(PWIDTH), .PULSE_SCALE(PSCALE), .UPDATE_CYCLES(UPD)
    ) dut_a (
        .clock(clock), .reset(reset), .dir(dir), .val(val), .done(done), .recenter(recenter),
        .position(pos_a), .pwm(pwm_a), .at_min(min_a), .at_max(max_a), .frame_start(fs_a)
    );

    servo_position_driver #(
        .PERIOD_CYCLES(PER), .PULSE_MIN(PWIDTH), .PULSE_SCALE(PSCALE), .UPDATE_CYCLES(UPD),
        .POS_MIN(8'd20)
    ) dut_b (
        .clock(clock), .reset(reset), .dir(dir), .val(val), .done(done), .recenter(recenter),
        .position(pos_b), .pwm(pwm_b), .at_min(min_b), .at_max(max_b), .frame_start(fs_b)
    );

    typedef struct packed {
        int pos;
        bit pv;
        bit pdir;
        int pval;
        int width;
    } mstate_t;

    typedef struct packed {
        logic [7:0] pos;
        logic       at_min;
        logic       at_max;
        logic       pwm;
        logic       fs;
    } obs_t;

    obs_t exp_a[$];
    obs_t exp_b[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   scyc = 0;

    function automatic int apply_step(int pos, bit d, int v, int pmin);
        if (!d) return (pos + v > PMAX) ? PMAX : pos + v;
        return (pos < pmin + v) ? pmin : pos - v;
    endfunction

    function automatic mstate_t reset_state();
        mstate_t s;
        s.pos = CENTER; s.pv = 1'b0; s.pdir = 1'b0; s.pval = 0; s.width = 0;
        return s;
    endfunction

    // One clock of the behaviour: the inputs are those present during the cycle that just ended.
    function automatic mstate_t model_next(mstate_t s, int pmin, bit tick, bit fs,
                                           bit rec, bit dn, bit d, int v);
        mstate_t n = s;
        if (fs) n.width = PWIDTH + s.pos * PSCALE;
        if (rec) begin
            n.pos = CENTER;
            n.pv  = 1'b0;
        end else if (tick) begin
            if (dn)        n.pos = apply_step(s.pos, d, v, pmin);
            else if (s.pv) n.pos = apply_step(s.pos, s.pdir, s.pval, pmin);
            n.pv = 1'b0;
        end else if (dn) begin
            n.pv = 1'b1; n.pdir = d; n.pval = v;
        end
        return n;
    endfunction

    function automatic obs_t model_obs(mstate_t s, int pmin, int cnt, bit rst);
        obs_t o;
        int   off = cnt % PER;
        o.pos    = 8'(s.pos);
        o.at_min = (s.pos == pmin);
        o.at_max = (s.pos == PMAX);
        o.pwm    = (off >= 1) && (off <= s.width);
        o.fs     = (off == 0) && !rst;
        return o;
    endfunction

    // Reference model: runs after the stimulus for the new cycle is applied.
    mstate_t ma, mb;
    int      mcnt = 0;
    bit      s_rst = 1'b1, s_rec = 1'b0, s_done = 1'b0, s_dir = 1'b0;
    int      s_val = 0;
    bit      m_tick, m_fs;

    always @(posedge clock) begin
        #2;
        if (s_rst) begin
            mcnt = 0;
            ma = reset_state();
            mb = reset_state();
        end else begin
            m_tick = (mcnt % UPD) == UPD - 1;
            m_fs   = (mcnt % PER) == 0;
            ma = model_next(ma, PMIN_A, m_tick, m_fs, s_rec, s_done, s_dir, s_val);
            mb = model_next(mb, PMIN_B, m_tick, m_fs, s_rec, s_done, s_dir, s_val);
            mcnt++;
        end
        exp_a.push_back(model_obs(ma, PMIN_A, mcnt, reset));
        exp_b.push_back(model_obs(mb, PMIN_B, mcnt, reset));
        s_rst = reset; s_rec = recenter; s_done = done; s_dir = dir; s_val = int'(val);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_obs(input string tag, input obs_t e, input logic [7:0] p,
                               input logic mn, input logic mx, input logic pw, input logic fs);
        check({tag, ".position"},    32'(p),  32'(e.pos));
        check({tag, ".at_min"},      32'(mn), 32'(e.at_min));
        check({tag, ".at_max"},      32'(mx), 32'(e.at_max));
        check({tag, ".pwm"},         32'(pw), 32'(e.pwm));
        check({tag, ".frame_start"}, 32'(fs), 32'(e.fs));
    endtask

    // Monitor: every cycle the DUTs present a full output set, compared mid-cycle.
    always @(negedge clock) begin
        if (exp_a.size() > 0 && exp_b.size() > 0) begin
            compare_obs("a", exp_a.pop_front(), pos_a, min_a, max_a, pwm_a, fs_a);
            compare_obs("b", exp_b.pop_front(), pos_b, min_b, max_b, pwm_b, fs_b);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        scyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_phase(input int period, input int rem);
        while (scyc % period != rem) step();
    endtask

    task automatic pulse(input bit d, input int v);
        dir = d; val = 8'(v); done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        run(n);
        reset = 1'b0;
        scyc = 0;
    endtask

    function automatic logic [7:0] rand_val();
        int r = $urandom_range(0, 9);
        if (r == 0) return 8'd255;
        if (r == 1) return 8'd0;
        return 8'($urandom_range(1, 40));
    endfunction

    initial begin
        int hold;
        int r;
        hold = 0;

        // Idle frame, then one pulse at cycle 10 applied at the cycle-49 tick.
        do_reset(3);
        run(10);
        pulse(1'b0, 5);
        run(1100);

        // GO mode: held decrement by 1 for 500 cycles.
        dir = 1'b1; val = 8'd1; done = 1'b1;
        run(500);
        done = 1'b0;
        run(20);

        // Lower clamp (0 for a, 20 for b) from position 25.
        recenter = 1'b1; step(); recenter = 1'b0;
        pulse(1'b1, 103);
        run(60);
        dir = 1'b1; val = 8'd10; done = 1'b1;
        run(200);
        done = 1'b0;

        // Upper clamp from position 250.
        recenter = 1'b1; step(); recenter = 1'b0;
        pulse(1'b0, 122);
        run(60);
        dir = 1'b0; val = 8'd10; done = 1'b1;
        run(150);
        done = 1'b0;
        run(10);

        // Latest request wins within one tick window.
        wait_phase(UPD, 5);
        pulse(1'b0, 3);
        run(10);
        pulse(1'b1, 7);
        run(50);

        // Recenter on a tick cycle discards the simultaneous request.
        wait_phase(UPD, UPD - 1);
        recenter = 1'b1; dir = 1'b0; val = 8'd20; done = 1'b1;
        step();
        recenter = 1'b0; done = 1'b0;
        run(60);

        // Position moves at frame cycle 200; this pulse keeps its width.
        wait_phase(PER, 150);
        pulse(1'b0, 40);
        run(1100);

        // Reset in the middle of a pulse.
        wait_phase(PER, 120);
        do_reset(1);
        run(1100);

        // Randomized traffic: pulses, held runs, recenters and rare resets.
        for (int i = 0; i < 3000; i++) begin
            done = 1'b0;
            recenter = 1'b0;
            if (hold > 0) begin
                hold--;
                done = 1'b1;
            end else begin
                r = $urandom_range(0, 199);
                if (r < 16) begin
                    dir = 1'($urandom_range(0, 1)); val = rand_val(); done = 1'b1;
                end else if (r < 20) begin
                    dir = 1'($urandom_range(0, 1)); val = rand_val(); done = 1'b1;
                    hold = $urandom_range(20, 200);
                end else if (r < 22) begin
                    recenter = 1'b1;
                    done = 1'($urandom_range(0, 1));
                end else if (r == 22 && $urandom_range(0, 9) == 0) begin
                    reset = 1'b1;
                end
            end
            step();
            if (reset) begin
                reset = 1'b0;
                scyc = 0;
            end
        end
        done = 1'b0;
        recenter = 1'b0;
        run(30);

        @(negedge clock);
        #1;
        check("scoreboard_activity", 32'(n_vec > 50000), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
